prog_loader: RTL and testbench

Program loader writing the 16×8 program store that the CPU fetches from during T0/T1. It replaces the fixed ROM contents with a byte stream received over a valid/ready handshake. It holds the CPU in reset while loading, verifies a checksum, and then releases the CPU. It also serves the CPU's instruction-fetch read port.

---
 rtl/cpu_defs_pkg.sv | 25 ++
 rtl/prog_loader_prog_ram.sv | 49 ++++
 rtl/prog_loader.sv | 168 ++++++++++++++++
 tb/tb_prog_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: loader defaults, loader state encodings and opcode constants.
package cpu_defs_pkg;

    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam logic [7:0]  SYNC_DEF   = 8'hA5;
    localparam int unsigned LEN_W      = 5;
    localparam int unsigned DATA_W     = 8;

    typedef enum logic [2:0] {
        S_SYNC   = 3'd0,
        S_LEN    = 3'd1,
        S_DATA   = 3'd2,
        S_SUM    = 3'd3,
        S_COMMIT = 3'd4,
        S_RUN    = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

endpackage

// File: rtl/prog_loader_prog_ram.sv
// Program store: DEPTH x 8 array, synchronous write, registered read.
// Ports: i_clk/i_rst clock and async active-low reset (read register only),
//        i_we/i_waddr/i_wdata write port, i_re/i_raddr read request,
//        o_rdata read data one cycle after request, 0 when not requested.
module prog_loader_prog_ram
    import cpu_defs_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    // Array is deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        rdata_d = 8'h00;
        if (i_re) begin
            rdata_d = mem[i_raddr];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a SYNC/LEN/DATA/SUM frame over valid/ready, writes
// the program store, holds the CPU in reset until a frame verifies, and serves
// the CPU fetch port with out-of-program addresses reading as 0x00.
// Ports: i_clk, i_rst (async active-low); i_valid/i_data/o_ready byte stream;
//        i_cpu_addr/i_cpu_en/o_cpu_data fetch port; o_cpu_rst_n CPU reset;
//        o_busy frame in progress; o_err last frame rejected; o_len program length.
module prog_loader
    import cpu_defs_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter logic [7:0]  SYNC   = SYNC_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [7:0]        i_data,
    output logic              o_ready,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic              i_cpu_en,
    output logic [7:0]        o_cpu_data,
    output logic              o_cpu_rst_n,
    output logic              o_busy,
    output logic              o_err,
    output logic [4:0]        o_len
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         sum_q, sum_d;
    logic [LEN_W-1:0]   len_out_q, len_out_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               cpu_rst_n_q, cpu_rst_n_d;

    logic               accept_c;
    logic               we_c;
    logic [ADDR_W-1:0]  waddr_c;
    logic               re_c;

    assign accept_c = i_valid & ready_q;
    assign waddr_c  = cnt_q[ADDR_W-1:0];

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        len_out_d   = len_out_q;
        err_d       = err_q;
        we_c        = 1'b0;

        case (state_q)
            S_SYNC: begin
                if (accept_c && i_data == SYNC) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (accept_c) begin
                    if (i_data == 8'h00 || i_data > 8'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = LEN_W'(i_data);
                        cnt_d   = '0;
                        sum_d   = 8'h00;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    we_c  = 1'b1;
                    sum_d = sum_q + i_data;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = S_SUM;
                    end
                end
            end
            S_SUM: begin
                if (accept_c) begin
                    state_d = (i_data == sum_q) ? S_COMMIT : S_ERR;
                end
            end
            S_COMMIT: begin
                state_d   = S_RUN;
                len_out_d = len_q;
                err_d     = 1'b0;
            end
            S_RUN, S_ERR: begin
                if (accept_c && i_data == SYNC) begin
                    state_d = S_LEN;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

        // Starting a new frame hides the old program; a rejection masks partial contents.
        if (state_d == S_LEN) begin
            len_out_d = '0;
        end
        if (state_d == S_ERR) begin
            err_d     = 1'b1;
            len_out_d = '0;
        end

        ready_d     = (state_d != S_COMMIT);
        busy_d      = (state_d == S_LEN) || (state_d == S_DATA) ||
                      (state_d == S_SUM) || (state_d == S_COMMIT);
        // Lags the state by one cycle so the CPU reset falls the cycle after a leaving SYNC.
        cpu_rst_n_d = (state_q == S_RUN);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_SYNC;
            len_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= 8'h00;
            len_out_q   <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            len_out_q   <= len_out_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    // Fetch: mask past the committed length and on a same-cycle write collision.
    assign re_c = i_cpu_en && (LEN_W'(i_cpu_addr) < len_out_q) &&
                  !(we_c && (waddr_c == i_cpu_addr));

    prog_loader_prog_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (we_c),
        .i_waddr (waddr_c),
        .i_wdata (i_data),
        .i_re    (re_c),
        .i_raddr (i_cpu_addr),
        .o_rdata (o_cpu_data)
    );

    assign o_ready     = ready_q;
    assign o_busy      = busy_q;
    assign o_err       = err_q;
    assign o_len       = len_out_q;
    assign o_cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: fetch expectations go through a scoreboard
// queue checked by an independent monitor; status outputs are checked inline.
module tb_prog_loader;

    logic       i_clk;
    logic       i_rst;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_ready;
    logic [3:0] i_cpu_addr;
    logic       i_cpu_en;
    logic [7:0] o_cpu_data;
    logic       o_cpu_rst_n;
    logic       o_busy;
    logic       o_err;
    logic [4:0] o_len;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    prog_loader dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .i_cpu_addr  (i_cpu_addr),
        .i_cpu_en    (i_cpu_en),
        .o_cpu_data  (o_cpu_data),
        .o_cpu_rst_n (o_cpu_rst_n),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_len       (o_len)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a fetch issued at an edge is compared after that edge.
    initial begin
        logic issued;
        forever begin
            @(posedge i_clk);
            issued = i_cpu_en;
            @(negedge i_clk);
            if (issued) begin
                if (exp_q.size() == 0) begin
                    check("fetch_unexpected", 32'(o_cpu_data), 32'hFFFF_FFFF);
                end else begin
                    check("fetch_data", 32'(o_cpu_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Present a byte and hold it until accepted (bounded).
    task automatic send(input logic [7:0] b);
        bit done = 1'b0;
        for (int t = 0; t < 10 && !done; t++) begin
            @(negedge i_clk);
            i_valid = 1'b1;
            i_data  = b;
            if (o_ready) begin
                @(posedge i_clk);
                done = 1'b1;
            end
        end
        if (!done) check("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle();
        @(negedge i_clk);
        i_valid = 1'b0;
        i_data  = 8'h00;
    endtask

    task automatic fetch(input logic [3:0] a, input logic [7:0] exp);
        @(negedge i_clk);
        i_cpu_en   = 1'b1;
        i_cpu_addr = a;
        exp_q.push_back(exp);
    endtask

    task automatic fetch_end();
        @(negedge i_clk);
        i_cpu_en = 1'b0;
        @(negedge i_clk);
    endtask

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] good[6];
        good = '{8'hA5, 8'h03, 8'h1A, 8'hE0, 8'hF0, 8'hEA};

        i_rst = 1'b0; i_valid = 1'b0; i_data = 8'h00;
        i_cpu_addr = 4'h0; i_cpu_en = 1'b0;
        #12;
        check("rst_ready",   32'(o_ready),     32'(1));
        check("rst_cpu_rst", 32'(o_cpu_rst_n), 32'(0));
        check("rst_len",     32'(o_len),       32'(0));
        check("rst_busy",    32'(o_busy),      32'(0));
        check("rst_err",     32'(o_err),       32'(0));
        check("rst_data",    32'(o_cpu_data),  32'(0));
        @(negedge i_clk);
        i_rst = 1'b1;
        fetch(4'd0, 8'h00);
        fetch_end();

        // Good frame, valid every cycle.
        foreach (good[i]) send(good[i]);
        idle();
        check("commit_ready", 32'(o_ready), 32'(0));
        check("commit_busy",  32'(o_busy),  32'(1));
        @(negedge i_clk);
        check("run_ready", 32'(o_ready), 32'(1));
        check("run_len",   32'(o_len),   32'(3));
        check("run_busy",  32'(o_busy),  32'(0));
        @(negedge i_clk);
        check("run_cpu_rst", 32'(o_cpu_rst_n), 32'(1));
        fetch(4'd0, 8'h1A);
        fetch(4'd1, 8'hE0);
        fetch(4'd2, 8'hF0);
        fetch(4'd3, 8'h00);
        fetch_end();

        // Bad checksum.
        for (int i = 0; i < 5; i++) send(good[i]);
        send(8'hEB);
        idle();
        check("bad_sum_err", 32'(o_err), 32'(1));
        check("bad_sum_len", 32'(o_len), 32'(0));
        @(negedge i_clk);
        check("bad_sum_cpu_rst", 32'(o_cpu_rst_n), 32'(0));
        fetch(4'd0, 8'h00);
        fetch(4'd1, 8'h00);
        fetch(4'd2, 8'h00);
        fetch_end();

        // Good frame clears the error.
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h33);
        idle();
        @(negedge i_clk);
        check("recover_err", 32'(o_err), 32'(0));
        check("recover_len", 32'(o_len), 32'(2));
        fetch(4'd0, 8'h11);
        fetch(4'd1, 8'h22);
        fetch(4'd2, 8'h00);
        fetch_end();

        // LEN = 0 and LEN = 0x11 are rejected; junk ignored until SYNC.
        send(8'hA5); send(8'h00);
        idle();
        check("len0_err",  32'(o_err),  32'(1));
        check("len0_busy", 32'(o_busy), 32'(0));
        check("len0_len",  32'(o_len),  32'(0));
        send(8'h00); send(8'h55);
        idle();
        check("junk_busy", 32'(o_busy), 32'(0));
        send(8'hA5);
        idle();
        check("sync_busy", 32'(o_busy), 32'(1));
        send(8'h11);
        idle();
        check("len17_err",  32'(o_err),  32'(1));
        check("len17_busy", 32'(o_busy), 32'(0));
        send(8'h00); send(8'h55);
        idle();
        check("junk2_busy", 32'(o_busy), 32'(0));

        // Full-depth frame with checksum wrap: 16 x FF, SUM F0.
        send(8'hA5); send(8'h10);
        for (int i = 0; i < 16; i++) send(8'hFF);
        send(8'hF0);
        idle();
        @(negedge i_clk);
        check("full_len", 32'(o_len), 32'(16));
        check("full_err", 32'(o_err), 32'(0));
        @(negedge i_clk);
        check("full_cpu_rst", 32'(o_cpu_rst_n), 32'(1));
        fetch(4'd0,  8'hFF);
        fetch(4'd15, 8'hFF);
        fetch_end();

        // SYNC aborts RUN; CPU reset falls one cycle later.
        send(8'hA5);
        idle();
        check("abort_len",        32'(o_len),       32'(0));
        check("abort_cpu_rst_lag", 32'(o_cpu_rst_n), 32'(1));
        @(negedge i_clk);
        check("abort_cpu_rst", 32'(o_cpu_rst_n), 32'(0));
        check("abort_busy",    32'(o_busy),      32'(1));

        // Async reset mid-DATA.
        send(8'h02); send(8'h11);
        idle();
        check("mid_busy", 32'(o_busy), 32'(1));
        #2;
        i_rst = 1'b0;
        #1;
        check("async_busy",  32'(o_busy),  32'(0));
        check("async_ready", 32'(o_ready), 32'(1));
        check("async_len",   32'(o_len),   32'(0));
        @(negedge i_clk);
        i_rst = 1'b1;
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7E);
        idle();
        @(negedge i_clk);
        check("fresh_len", 32'(o_len), 32'(1));
        @(negedge i_clk);
        check("fresh_cpu_rst", 32'(o_cpu_rst_n), 32'(1));
        fetch(4'd0, 8'h7E);
        fetch(4'd1, 8'h00);
        fetch_end();

        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
